// File: rtl/preg_release_queue_pkg.sv
// -----------------------------------------------------------------------------
// preg_release_queue_pkg
//   Shared physical-register types for free_list, the map tables and the
//   retire-side release queue.
//   Contents:
//     PREG_IDX               - physical register index, `PHYS_REG_IDX_SZ+1 bits
//     DEFAULT_DEPTH          - default release queue depth
//     DEFAULT_RETIRE_WIDTH   - default number of retire lanes
// -----------------------------------------------------------------------------
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package preg_release_queue_pkg;

    typedef logic [`PHYS_REG_IDX_SZ:0] PREG_IDX;

    localparam int unsigned DEFAULT_DEPTH        = 8;
    localparam int unsigned DEFAULT_RETIRE_WIDTH = 2;

endpackage

// File: rtl/preg_release_queue_if.sv
// -----------------------------------------------------------------------------
// preg_release_queue_if
//   Bundles the retire-side push port, the free_list enqueue port and the
//   occupancy status of the release queue.
//   Signals:
//     retire_valid   - per-lane flag, lane frees a PR this cycle
//     retire_old_pr  - PR freed by each lane
//     retire_ready   - queue can take a full retire group this cycle
//     enqueue_en     - request to free_list to enqueue enqueue_pr
//     enqueue_pr     - PR at the head of the queue
//     was_enqueued   - free_list accepted enqueue_pr this cycle
//     count          - occupied entries (registered)
//     empty          - count == 0
//   Modports:
//     master - retire stage plus free_list (drives retire/was_enqueued)
//     slave  - the release queue itself
// -----------------------------------------------------------------------------
interface preg_release_queue_if
    import preg_release_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned RETIRE_WIDTH = DEFAULT_RETIRE_WIDTH
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [RETIRE_WIDTH-1:0]          retire_valid;
    PREG_IDX [RETIRE_WIDTH-1:0]       retire_old_pr;
    logic                             retire_ready;
    logic                             enqueue_en;
    PREG_IDX                          enqueue_pr;
    logic                             was_enqueued;
    logic [CNT_W-1:0]                 count;
    logic                             empty;

    modport master (
        output retire_valid,
        output retire_old_pr,
        input  retire_ready,
        input  enqueue_en,
        input  enqueue_pr,
        output was_enqueued,
        input  count,
        input  empty
    );

    modport slave (
        input  retire_valid,
        input  retire_old_pr,
        output retire_ready,
        output enqueue_en,
        output enqueue_pr,
        input  was_enqueued,
        output count,
        output empty
    );

endinterface

// File: rtl/preg_release_queue_lane_compactor.sv
// -----------------------------------------------------------------------------
// preg_release_queue_lane_compactor
//   Combinational packer: moves the PRs of the valid lanes into consecutive
//   write slots (lane order preserved, slot 0 first) and reports how many
//   slots are in use.
//   Ports:
//     lane_valid - per-lane valid flags
//     lane_pr    - per-lane PR values
//     slot_pr    - packed PRs, slot 0 holds the lowest valid lane
//     slot_cnt   - popcount(lane_valid)
// -----------------------------------------------------------------------------
module preg_release_queue_lane_compactor
    import preg_release_queue_pkg::*;
#(
    parameter int unsigned RETIRE_WIDTH = DEFAULT_RETIRE_WIDTH,
    localparam int unsigned SLOT_CNT_W  = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic [RETIRE_WIDTH-1:0]    lane_valid,
    input  PREG_IDX [RETIRE_WIDTH-1:0] lane_pr,
    output PREG_IDX [RETIRE_WIDTH-1:0] slot_pr,
    output logic [SLOT_CNT_W-1:0]      slot_cnt
);

    // slot_cnt doubles as the running slot position while scanning lanes;
    // comparing against each slot index avoids a variable-width array select.
    always_comb begin
        slot_pr  = '0;
        slot_cnt = '0;
        for (int unsigned l = 0; l < RETIRE_WIDTH; l++) begin
            if (lane_valid[l]) begin
                for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
                    if (slot_cnt == SLOT_CNT_W'(s)) begin
                        slot_pr[s] = lane_pr[l];
                    end
                end
                slot_cnt = slot_cnt + SLOT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/preg_release_queue.sv
// -----------------------------------------------------------------------------
// preg_release_queue
//   Retire-side producer for the free_list enqueue port. Stale PRs freed by up
//   to RETIRE_WIDTH retiring instructions per cycle are buffered in a circular
//   FIFO and drained one per cycle into free_list.
//   Ports:
//     clk   - system clock, all state updates on posedge
//     reset - synchronous, active-high; discards all buffered PRs
//     bus   - preg_release_queue_if.slave (retire push, enqueue pop, status)
//   Notes:
//     retire_ready depends only on the registered count, so a same-cycle pop
//     never raises it and was_enqueued has no combinational path to retire.
//     A PR pushed this cycle is visible on enqueue_pr from the next cycle.
// -----------------------------------------------------------------------------
module preg_release_queue
    import preg_release_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned RETIRE_WIDTH = DEFAULT_RETIRE_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    preg_release_queue_if.slave  bus
);

    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned SLOT_CNT_W = $clog2(RETIRE_WIDTH + 1);

    // Largest count at which a full retire group still fits.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - RETIRE_WIDTH);

    PREG_IDX                      mem [DEPTH];
    logic [PTR_W-1:0]             head_q;
    logic [PTR_W-1:0]             tail_q;
    logic [CNT_W-1:0]             count_q;

    PREG_IDX [RETIRE_WIDTH-1:0]   slot_pr;
    logic [SLOT_CNT_W-1:0]        slot_cnt;
    logic [SLOT_CNT_W-1:0]        push_cnt;
    logic                         retire_ready;
    logic                         empty;
    logic                         pop;
    logic [CNT_W-1:0]             count_next;

    preg_release_queue_lane_compactor #(
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) u_lane_compactor (
        .lane_valid (bus.retire_valid),
        .lane_pr    (bus.retire_old_pr),
        .slot_pr    (slot_pr),
        .slot_cnt   (slot_cnt)
    );

    always_comb begin
        retire_ready = (count_q <= READY_MAX);
        empty        = (count_q == '0);
        push_cnt     = retire_ready ? slot_cnt : '0;
        pop          = !empty && bus.was_enqueued;
        count_next   = count_q + CNT_W'(push_cnt) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
                if (SLOT_CNT_W'(s) < push_cnt) begin
                    mem[tail_q + PTR_W'(s)] <= slot_pr[s];
                end
            end
            tail_q  <= tail_q + PTR_W'(push_cnt);
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    assign bus.retire_ready = retire_ready;
    assign bus.enqueue_en   = !empty;
    assign bus.enqueue_pr   = empty ? '0 : mem[head_q];
    assign bus.count        = count_q;
    assign bus.empty        = empty;

endmodule

// File: tb/tb_preg_release_queue.sv
// -----------------------------------------------------------------------------
// tb_preg_release_queue
//   Directed bench for preg_release_queue (DEPTH=8, RETIRE_WIDTH=2).
// -----------------------------------------------------------------------------
module tb_preg_release_queue;
    import preg_release_queue_pkg::*;

    localparam int unsigned DEPTH        = 8;
    localparam int unsigned RETIRE_WIDTH = 2;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;
    int drop_events;

    preg_release_queue_if #(
        .DEPTH        (DEPTH),
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) bus ();

    preg_release_queue #(
        .DEPTH        (DEPTH),
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire presenting valid lanes while not ready: those lanes are dropped,
    // retire is expected to hold them. Counted and compared at the end.
    always @(posedge clk) begin
        if (!reset && !bus.retire_ready && (|bus.retire_valid)) begin
            drop_events = drop_events + 1;
            $display("note: retire lanes presented while retire_ready=0 at %0t", $time);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [1:0] v, input int pr0, input int pr1);
        bus.retire_valid     = v;
        bus.retire_old_pr[0] = PREG_IDX'(pr0);
        bus.retire_old_pr[1] = PREG_IDX'(pr1);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        drop_events = 0;

        // Reset with both lanes valid: nothing may be written.
        reset            = 1'b1;
        bus.was_enqueued = 1'b0;
        retire(2'b11, 3, 4);
        tick();
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_en", int'(bus.enqueue_en), 0);
        check("rst_ready", int'(bus.retire_ready), 1);
        check("rst_pr", int'(bus.enqueue_pr), 0);
        reset = 1'b0;
        retire(2'b00, 0, 0);
        tick();
        check("post_rst_count", int'(bus.count), 0);

        // Two-lane group drained back to back.
        bus.was_enqueued = 1'b1;
        retire(2'b11, 5, 9);
        #1;
        check("no_bypass_en", int'(bus.enqueue_en), 0);
        tick();
        check("g2_count", int'(bus.count), 2);
        check("g2_pr0", int'(bus.enqueue_pr), 5);
        retire(2'b00, 0, 0);
        tick();
        check("g2_pr1", int'(bus.enqueue_pr), 9);
        check("g2_count1", int'(bus.count), 1);
        tick();
        check("g2_empty", int'(bus.empty), 1);
        check("g2_en_off", int'(bus.enqueue_en), 0);
        bus.was_enqueued = 1'b0;

        // Lane 1 only, free_list stalls three cycles.
        retire(2'b10, 7, 12);
        tick();
        retire(2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall_en", int'(bus.enqueue_en), 1);
            check("stall_pr", int'(bus.enqueue_pr), 12);
            check("stall_count", int'(bus.count), 1);
            tick();
        end
        bus.was_enqueued = 1'b1;
        tick();
        check("stall_drain_count", int'(bus.count), 0);
        check("stall_drain_empty", int'(bus.empty), 1);
        bus.was_enqueued = 1'b0;

        // Fill to DEPTH, try a fifth group, then drain across the wrap.
        for (int g = 0; g < 4; g++) begin
            check("fill_ready", int'(bus.retire_ready), 1);
            retire(2'b11, 2 * g + 1, 2 * g + 2);
            tick();
            check("fill_count", int'(bus.count), 2 * g + 2);
        end
        check("full_ready", int'(bus.retire_ready), 0);
        retire(2'b11, 20, 21);
        tick();
        check("full_drop_count", int'(bus.count), 8);
        retire(2'b00, 0, 0);
        bus.was_enqueued = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check("drain_pr", int'(bus.enqueue_pr), k);
            tick();
        end
        check("drain_empty", int'(bus.empty), 1);
        bus.was_enqueued = 1'b0;

        // Count 7: same-cycle pop does not reopen retire_ready.
        retire(2'b11, 10, 11);
        tick();
        retire(2'b11, 12, 13);
        tick();
        retire(2'b11, 14, 15);
        tick();
        retire(2'b01, 30, 0);
        tick();
        check("c7_count", int'(bus.count), 7);
        check("c7_ready", int'(bus.retire_ready), 0);
        retire(2'b01, 40, 0);
        bus.was_enqueued = 1'b1;
        tick();
        check("c7_pop_count", int'(bus.count), 6);
        check("c7_pop_ready", int'(bus.retire_ready), 1);
        check("c7_pop_pr", int'(bus.enqueue_pr), 11);
        retire(2'b00, 0, 0);
        tick();
        check("c5_count", int'(bus.count), 5);

        // Reset with 5 buffered entries and a push pending.
        reset            = 1'b1;
        bus.was_enqueued = 1'b0;
        retire(2'b11, 60, 61);
        tick();
        check("mid_rst_count", int'(bus.count), 0);
        check("mid_rst_empty", int'(bus.empty), 1);
        check("mid_rst_pr", int'(bus.enqueue_pr), 0);
        reset = 1'b0;
        retire(2'b00, 0, 0);
        tick();
        check("mid_rst_en", int'(bus.enqueue_en), 0);
        retire(2'b01, 50, 0);
        tick();
        retire(2'b00, 0, 0);
        check("post_rst_pr", int'(bus.enqueue_pr), 50);
        check("post_rst_count1", int'(bus.count), 1);
        bus.was_enqueued = 1'b1;
        tick();
        check("post_rst_drain", int'(bus.count), 0);
        check("post_rst_pr0", int'(bus.enqueue_pr), 0);
        bus.was_enqueued = 1'b0;

        check("drop_events", drop_events, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
